// File: rtl/dmem_access_pkg.sv
// Shared encodings and lane helpers for the data-memory access unit.
package dmem_access_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } state_t;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // Byte lanes touched by an access of the given size at byte offset off.
  function automatic logic [NUM_LANES-1:0] lane_sel(input logic [1:0] size,
                                                    input logic [1:0] off);
    logic [NUM_LANES-1:0] one;
    one = 4'b0001;
    case (size)
      SIZE_BYTE: lane_sel = one << off;
      SIZE_HALF: lane_sel = {off[1], off[1], ~off[1], ~off[1]};
      default:   lane_sel = 4'b1111;
    endcase
  endfunction

  // Illegal size or an offset not aligned to the access size.
  function automatic logic bad_access(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: bad_access = 1'b0;
      SIZE_HALF: bad_access = off[0];
      SIZE_WORD: bad_access = (off != 2'b00);
      default:   bad_access = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
module dmem_lane_align
  import dmem_access_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  off,
  input  logic [31:0] rd_word,
  input  logic [31:0] st_old,
  input  logic [31:0] st_data,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  logic [NUM_LANES-1:0]             sel;
  logic [NUM_LANES-1:0][LANE_W-1:0] old_l, dat_l, out_l;
  logic [31:0]                      sh;

  assign sel     = lane_sel(size, off);
  assign old_l   = st_old;
  assign dat_l   = st_data;
  assign st_word = out_l;

  // Each lane takes the matching low byte of store data when selected, else keeps memory.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic [LANE_W-1:0] src;
    always_comb begin
      case (size)
        SIZE_BYTE: src = dat_l[0];
        SIZE_HALF: src = dat_l[k % 2];
        default:   src = dat_l[k];
      endcase
      out_l[k] = sel[k] ? src : old_l[k];
    end
  end

  // Shift the addressed lane down to bit 0, then sign- or zero-extend.
  always_comb begin
    sh = rd_word >> {off, 3'b000};
    case (size)
      SIZE_BYTE: ld_data = {{24{~uns & sh[7]}},  sh[7:0]};
      SIZE_HALF: ld_data = {{16{~uns & sh[15]}}, sh[15:0]};
      default:   ld_data = rd_word;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage bus initiator: one load/store per request, RMW for sub-word stores.
module dmem_access_unit
  import dmem_access_pkg::*;
#(
  parameter int MEM_WAIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_dout
);

  state_t      state_q, state_d;
  req_t        req_q;
  logic [3:0]  cnt_q;
  logic [31:0] data_q, rdata_q, ld_data, st_word, st_old;
  logic        err_q, accept, req_bad, rd_last;

  assign accept  = req_valid & (state_q == ST_IDLE);
  assign req_bad = bad_access(req_size, req_addr[1:0]);
  assign rd_last = (state_q == ST_RD) && (cnt_q == 4'(MEM_WAIT));
  // Merge source is live memory during RD and the captured word during WR; both are equal.
  assign st_old  = (state_q == ST_WR) ? data_q : mem_dout;

  dmem_lane_align u_align (
    .size    (req_q.size),
    .uns     (req_q.uns),
    .off     (req_q.addr[1:0]),
    .rd_word (mem_dout),
    .st_old  (st_old),
    .st_data (req_q.wdata),
    .ld_data (ld_data),
    .st_word (st_word)
  );

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        if (req_bad)                               state_d = ST_RESP;
        else if (req_write && req_size == SIZE_WORD) state_d = ST_WR;
        else                                       state_d = ST_RD;
      end
      ST_RD:   if (rd_last) state_d = req_q.write ? ST_WR : ST_RESP;
      ST_WR:   state_d = ST_RESP;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, wait counter, request latch, read capture and response data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_RD) cnt_q <= rd_last ? 4'd0 : cnt_q + 4'd1;
      else                  cnt_q <= '0;
      if (accept) begin
        req_q <= '{write: req_write, size: req_size, uns: req_unsigned,
                   addr: req_addr, wdata: req_wdata};
        err_q <= req_bad;
      end
      if (rd_last) data_q <= mem_dout;
      if (state_d == ST_RESP && state_q != ST_RESP)
        rdata_q <= (rd_last && !req_q.write) ? ld_data : 32'd0;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign mem_read   = (state_q == ST_RD);
  assign mem_write  = (state_q == ST_WR);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = rdata_q;
  assign mem_addr   = {req_q.addr[31:2], 2'b00};
  assign mem_din    = req_q.write ? st_word : 32'd0;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench: two units (MEM_WAIT 0 and 3), each with its own word memory and reference model.
module tb_dmem_access_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid[2], req_ready[2], req_write[2], req_unsigned[2];
  logic        resp_valid[2], resp_err[2], mem_read[2], mem_write[2];
  logic [1:0]  req_size[2];
  logic [31:0] req_addr[2], req_wdata[2], resp_rdata[2];
  logic [31:0] mem_addr[2], mem_din[2], mem_dout[2];

  logic [31:0] mem     [2][64];
  logic [31:0] exp_mem [2][64];
  logic        bd_we, bd_clr;
  int          bd_u;
  logic [5:0]  bd_a;
  logic [31:0] bd_d;

  int errors = 0;
  int checks = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmem_access_unit #(.MEM_WAIT(g * 3)) u_dut (
      .clk          (clk),
      .reset        (rst_n),
      .req_valid    (req_valid[g]),
      .req_ready    (req_ready[g]),
      .req_write    (req_write[g]),
      .req_size     (req_size[g]),
      .req_unsigned (req_unsigned[g]),
      .req_addr     (req_addr[g]),
      .req_wdata    (req_wdata[g]),
      .resp_valid   (resp_valid[g]),
      .resp_rdata   (resp_rdata[g]),
      .resp_err     (resp_err[g]),
      .mem_addr     (mem_addr[g]),
      .mem_din      (mem_din[g]),
      .mem_read     (mem_read[g]),
      .mem_write    (mem_write[g]),
      .mem_dout     (mem_dout[g])
    );
    assign mem_dout[g] = mem[g][mem_addr[g][7:2]];
  end

  // Word memories: async read, sync write, plus a backdoor for preloading.
  always @(posedge clk) begin
    if (bd_clr) begin
      for (int i = 0; i < 64; i++) begin
        mem[0][i] <= 32'd0;
        mem[1][i] <= 32'd0;
      end
    end else if (bd_we) mem[bd_u][bd_a] <= bd_d;
    for (int g = 0; g < 2; g++)
      if (mem_write[g]) mem[g][mem_addr[g][7:2]] <= mem_din[g];
  end

  // Reference: outcome of one request from the access rules, with plain arithmetic.
  function automatic void model(input int w, input logic wr, input logic [1:0] sz,
                                input logic un, input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] old, output logic err, output logic [31:0] rd,
                                output logic [31:0] nw, output int lat, output int nrd,
                                output int nwr);
    int nbytes, sh;
    logic [63:0] m, v;
    err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    rd = 32'd0; nw = old; lat = 1; nrd = 0; nwr = 0;
    if (!err) begin
      nbytes = 1 << sz;
      sh = 8 * int'(a[1:0]);
      m = ((64'd1 << (8 * nbytes)) - 64'd1) << sh;
      if (wr) begin
        v = {32'd0, wd} << sh;
        v = ({32'd0, old} & ~m) | (v & m);
        nw = v[31:0];
        nwr = 1;
        nrd = (nbytes == 4) ? 0 : w + 1;
        lat = (nbytes == 4) ? 2 : 3 + w;
      end else begin
        v = ({32'd0, old} & m) >> sh;
        if (!un && nbytes < 4 && v[8 * nbytes - 1])
          v = v | ~((64'd1 << (8 * nbytes)) - 64'd1);
        rd = v[31:0];
        nrd = w + 1;
        lat = 2 + w;
      end
    end
  endfunction

  task automatic bd_write(input int u, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_u = u; bd_a = a[7:2]; bd_d = d;
    @(negedge clk);
    bd_we = 1'b0;
    exp_mem[u][a[7:2]] = d;
  endtask

  // One full request on unit u, starting and ending at a negedge with the unit idle.
  task automatic do_req(input int u, input logic wr, input logic [1:0] sz, input logic un,
                        input logic [31:0] a, input logic [31:0] wd, input string tag);
    logic e_err;
    logic [31:0] e_rd, e_nw;
    int lat, nrd, nwr, n, rdc, wrc, both, resp_at, addr_bad, din_bad;
    model(u * 3, wr, sz, un, a, wd, exp_mem[u][a[7:2]], e_err, e_rd, e_nw, lat, nrd, nwr);
    checks++;
    if (req_ready[u] !== 1'b1) begin
      errors++; $display("FAIL %s ready-before: got %b want 1", tag, req_ready[u]);
    end
    req_valid[u] = 1'b1; req_write[u] = wr; req_size[u] = sz; req_unsigned[u] = un;
    req_addr[u] = a; req_wdata[u] = wd;
    @(posedge clk);
    @(negedge clk);
    // Fields scrambled after accept must not matter.
    req_valid[u] = 1'b0; req_write[u] = 1'($urandom); req_size[u] = 2'($urandom);
    req_addr[u] = $urandom; req_wdata[u] = $urandom; req_unsigned[u] = 1'($urandom);
    n = 1; resp_at = -1; rdc = 0; wrc = 0; both = 0; addr_bad = 0; din_bad = 0;
    while (resp_at < 0 && n <= 40) begin
      if (mem_read[u]) rdc++;
      if (mem_write[u]) wrc++;
      if (mem_read[u] && mem_write[u]) both++;
      if ((mem_read[u] || mem_write[u]) && mem_addr[u] !== {a[31:2], 2'b00}) addr_bad++;
      if (mem_write[u] && mem_din[u] !== e_nw) din_bad++;
      if (resp_valid[u]) begin
        resp_at = n;
        checks++;
        if (resp_rdata[u] !== e_rd || resp_err[u] !== e_err) begin
          errors++;
          $display("FAIL %s resp: got rdata=%h err=%b want rdata=%h err=%b",
                   tag, resp_rdata[u], resp_err[u], e_rd, e_err);
        end
      end else begin
        @(negedge clk);
        n++;
      end
    end
    checks++;
    if (resp_at != lat) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", tag, resp_at, lat);
    end
    checks++;
    if (rdc != nrd || wrc != nwr || both != 0 || addr_bad != 0 || din_bad != 0) begin
      errors++;
      $display("FAIL %s strobes: got rd=%0d wr=%0d both=%0d addr_bad=%0d din_bad=%0d want rd=%0d wr=%0d",
               tag, rdc, wrc, both, addr_bad, din_bad, nrd, nwr);
    end
    checks++;
    if (mem[u][a[7:2]] !== e_nw) begin
      errors++; $display("FAIL %s mem: got %h want %h", tag, mem[u][a[7:2]], e_nw);
    end
    exp_mem[u][a[7:2]] = e_nw;
    @(negedge clk);
    checks++;
    if (resp_valid[u] !== 1'b0 || req_ready[u] !== 1'b1 || resp_rdata[u] !== e_rd) begin
      errors++;
      $display("FAIL %s after-resp: got valid=%b ready=%b rdata=%h want 0 1 %h",
               tag, resp_valid[u], req_ready[u], resp_rdata[u], e_rd);
    end
  endtask

  task automatic test_reset();
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({req_ready[u], resp_valid[u], resp_err[u], mem_read[u], mem_write[u]} !== 5'b10000) begin
        errors++;
        $display("FAIL reset ctl u%0d: got %b want 10000", u,
                 {req_ready[u], resp_valid[u], resp_err[u], mem_read[u], mem_write[u]});
      end
      checks++;
      if ({resp_rdata[u], mem_addr[u], mem_din[u]} !== 96'd0) begin
        errors++;
        $display("FAIL reset data u%0d: got rdata=%h addr=%h din=%h want 0",
                 u, resp_rdata[u], mem_addr[u], mem_din[u]);
      end
    end
  endtask

  task automatic lit_check(input int u, input logic [31:0] got, input logic [31:0] want,
                           input string tag);
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic test_loads();
    bd_write(0, 32'h10, 32'h8899AABB);
    do_req(0, 1'b0, 2'd0, 1'b0, 32'h13, 32'd0, "lb");
    lit_check(0, resp_rdata[0], 32'hFFFFFF88, "lb value");
    do_req(0, 1'b0, 2'd0, 1'b1, 32'h13, 32'd0, "lbu");
    lit_check(0, resp_rdata[0], 32'h00000088, "lbu value");
    do_req(0, 1'b0, 2'd1, 1'b0, 32'h12, 32'd0, "lh");
    lit_check(0, resp_rdata[0], 32'hFFFF8899, "lh value");
    do_req(0, 1'b0, 2'd1, 1'b1, 32'h10, 32'd0, "lhu");
  endtask

  task automatic test_word_store();
    do_req(0, 1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF, "sw");
    lit_check(0, mem[0][8], 32'hDEADBEEF, "sw mem");
    do_req(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0, "lw");
    lit_check(0, resp_rdata[0], 32'hDEADBEEF, "lw value");
  endtask

  task automatic test_rmw();
    bd_write(0, 32'h30, 32'h11223344);
    do_req(0, 1'b1, 2'd0, 1'b0, 32'h31, 32'h000000AB, "sb");
    lit_check(0, mem[0][12], 32'h1122AB44, "sb mem");
    do_req(0, 1'b1, 2'd1, 1'b0, 32'h32, 32'h0000CDEF, "sh");
    lit_check(0, mem[0][12], 32'hCDEFAB44, "sh mem");
  endtask

  task automatic test_errors();
    bd_write(0, 32'h40, 32'h55667788);
    do_req(0, 1'b0, 2'd1, 1'b0, 32'h41, 32'd0, "err lh");
    do_req(0, 1'b0, 2'd2, 1'b0, 32'h42, 32'd0, "err lw");
    do_req(0, 1'b0, 2'd3, 1'b0, 32'h40, 32'd0, "err size");
    do_req(0, 1'b1, 2'd2, 1'b0, 32'h43, 32'hFFFFFFFF, "err sw");
    do_req(0, 1'b1, 2'd3, 1'b0, 32'h40, 32'hFFFFFFFF, "err ss");
    lit_check(0, mem[0][16], 32'h55667788, "err mem");
  endtask

  task automatic test_wait();
    bd_write(1, 32'h60, 32'hCAFEF00D);
    do_req(1, 1'b0, 2'd2, 1'b0, 32'h60, 32'd0, "w3 lw");
    do_req(1, 1'b1, 2'd0, 1'b0, 32'h62, 32'h0000005A, "w3 sb");
    lit_check(1, mem[1][24], 32'hCA5AF00D, "w3 sb mem");
  endtask

  task automatic test_back_to_back();
    int first, second, rdy_bad;
    logic [31:0] r1, r2;
    bd_write(1, 32'h64, 32'h01020304);
    bd_write(1, 32'h68, 32'hA0B0C0D0);
    first = -1; second = -1; rdy_bad = 0; r1 = 0; r2 = 0;
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_size[1] = 2'd2; req_unsigned[1] = 1'b0;
    req_addr[1] = 32'h64; req_wdata[1] = 32'd0;
    @(posedge clk);
    @(negedge clk);
    req_addr[1] = 32'h68;
    for (int n = 1; n <= 16; n++) begin
      if (resp_valid[1]) begin
        if (first < 0) begin first = n; r1 = resp_rdata[1]; end
        else begin second = n; r2 = resp_rdata[1]; end
      end
      if (n <= 5 && req_ready[1]) rdy_bad++;
      if (n == 7) req_valid[1] = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (first != 5 || second != 11 || rdy_bad != 0) begin
      errors++;
      $display("FAIL b2b timing: got first=%0d second=%0d early_ready=%0d want 5 11 0",
               first, second, rdy_bad);
    end
    checks++;
    if (r1 !== 32'h01020304 || r2 !== 32'hA0B0C0D0) begin
      errors++; $display("FAIL b2b data: got %h %h want 01020304 a0b0c0d0", r1, r2);
    end
  endtask

  task automatic test_random();
    int u;
    for (int i = 0; i < 40; i++) begin
      u = int'($urandom_range(0, 1));
      do_req(u, 1'($urandom), 2'($urandom), 1'($urandom), 32'($urandom_range(0, 255)),
             $urandom, "rand");
    end
  endtask

  task automatic test_reset_mid();
    for (int ph = 1; ph <= 2; ph++) begin
      bd_write(0, 32'h50, 32'h13579BDF);
      req_valid[0] = 1'b1; req_write[0] = 1'b1; req_size[0] = 2'd0; req_unsigned[0] = 1'b0;
      req_addr[0] = 32'h50; req_wdata[0] = 32'h000000EE;
      @(posedge clk);
      @(negedge clk);
      req_valid[0] = 1'b0;
      if (ph == 2) @(negedge clk);
      checks++;
      if ({mem_read[0], mem_write[0]} !== ((ph == 1) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL rst-mid phase%0d pre: got rd/wr=%b", ph, {mem_read[0], mem_write[0]});
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({mem_read[0], mem_write[0], req_ready[0], resp_valid[0]} !== 4'b0010) begin
        errors++;
        $display("FAIL rst-mid phase%0d strobes: got %b want 0010", ph,
                 {mem_read[0], mem_write[0], req_ready[0], resp_valid[0]});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (mem[0][20] !== 32'h13579BDF || req_ready[0] !== 1'b1) begin
        errors++;
        $display("FAIL rst-mid phase%0d mem: got %h ready=%b want 13579bdf 1", ph, mem[0][20], req_ready[0]);
      end
    end
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 1'b0; req_write[u] = 1'b0; req_size[u] = 2'd0; req_unsigned[u] = 1'b0;
      req_addr[u] = 32'd0; req_wdata[u] = 32'd0;
      for (int i = 0; i < 64; i++) exp_mem[u][i] = 32'd0;
    end
    bd_we = 1'b0; bd_clr = 1'b1; bd_u = 0; bd_a = 6'd0; bd_d = 32'd0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    bd_clr = 1'b0;
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_loads();
    test_word_store();
    test_rmw();
    test_errors();
    test_wait();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
